// File: rtl/mc_pkg.sv
// Shared definitions for the mc_core microcontroller: FSM states, opcodes
// and instruction field positions.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_JAL  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_LI   = 4'hB;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_SW   = 4'hD;
    localparam logic [3:0] OP_SLT  = 4'hE;
    localparam logic [3:0] OP_SGT  = 4'hF;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 8;
    localparam int unsigned RS_MSB = 7;
    localparam int unsigned RS_LSB = 4;
    localparam int unsigned RT_MSB = 3;
    localparam int unsigned RT_LSB = 0;

    // JAL always links into the top architectural register
    localparam logic [3:0] LINK_REG = 4'hF;

    // BEQ compares rd against rs and SW stores rd, so the second read
    // port fetches rd instead of rt for these two opcodes
    function automatic logic uses_rd_operand(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: three combinational read ports, one synchronous write port.
// R0 and any index at or above NREGS read as zero and ignore writes.
module mc_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [3:0]        rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [3:0]        rc_addr_i,
    output logic [DATA_W-1:0] rc_data_o,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    // Full 16-entry array; unimplemented entries are never written and stay zero
    logic [DATA_W-1:0] regs_q [16];

    assign ra_data_o = (int'(ra_addr_i) < NREGS) ? regs_q[ra_addr_i] : '0;
    assign rb_data_o = (int'(rb_addr_i) < NREGS) ? regs_q[rb_addr_i] : '0;
    assign rc_data_o = (int'(rc_addr_i) < NREGS) ? regs_q[rc_addr_i] : '0;

    // Async clear on reset; gated write keeps R0 and unimplemented entries at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 4'd0) && (int'(waddr_i) < NREGS)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 16-bit-instruction microcontroller core:
// FETCH -> DECODE -> EXEC (-> MEM) -> FETCH, HALT on opcode 0000.
module mc_core
    import mc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 6,
    parameter int ADDR_W = 8,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted,
    input  logic [3:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic              imem_req_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [DATA_W-1:0] dmem_wdata_q;
    logic              retire_q;
    logic              halted_q;

    logic [3:0]        op, rd_idx, rs_idx, rt_idx;
    logic [DATA_W-1:0] imm4_sx, imm8_zx;
    logic [PC_W-1:0]   tgt, pc_plus1, pc_branch;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] rf_ra_data, rf_rb_data;
    logic [3:0]        rf_rb_addr;
    logic [DATA_W-1:0] alu_res;
    logic              alu_wb;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign op       = instr_q[OP_MSB:OP_LSB];
    assign rd_idx   = instr_q[RD_MSB:RD_LSB];
    assign rs_idx   = instr_q[RS_MSB:RS_LSB];
    assign rt_idx   = instr_q[RT_MSB:RT_LSB];
    assign imm4_sx  = {{(DATA_W-4){instr_q[RT_MSB]}}, instr_q[RT_MSB:RT_LSB]};
    assign imm8_zx  = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
    assign tgt      = instr_q[PC_W-1:0];
    assign pc_plus1  = pc_q + PC_W'(1);
    assign pc_branch = pc_plus1 + imm4_sx[PC_W-1:0];
    assign mem_addr  = ADDR_W'(opa_q + imm4_sx);
    assign rf_rb_addr = uses_rd_operand(op) ? rd_idx : rt_idx;

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign retire     = retire_q;
    assign halted     = halted_q;

    mc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .ra_addr_i (rs_idx),
        .ra_data_o (rf_ra_data),
        .rb_addr_i (rf_rb_addr),
        .rb_data_o (rf_rb_data),
        .rc_addr_i (dbg_raddr),
        .rc_data_o (dbg_rdata),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

    // Result of register-writing ops from the operands latched in DECODE
    always_comb begin
        alu_res = '0;
        alu_wb  = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = opa_q + opb_q;   alu_wb = 1'b1; end
            OP_ADDI: begin alu_res = opa_q + imm4_sx; alu_wb = 1'b1; end
            OP_MUL:  begin alu_res = opa_q * opb_q;   alu_wb = 1'b1; end
            OP_AND:  begin alu_res = opa_q & opb_q;   alu_wb = 1'b1; end
            OP_OR:   begin alu_res = opa_q | opb_q;   alu_wb = 1'b1; end
            OP_SUB:  begin alu_res = opa_q - opb_q;   alu_wb = 1'b1; end
            OP_MOV:  begin alu_res = opa_q;           alu_wb = 1'b1; end
            OP_LI:   begin alu_res = imm8_zx;         alu_wb = 1'b1; end
            OP_JAL:  begin alu_res = DATA_W'(pc_plus1); alu_wb = 1'b1; end
            OP_SLT: begin
                alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
                alu_wb  = 1'b1;
            end
            OP_SGT: begin
                alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa_q) > $signed(opb_q))};
                alu_wb  = 1'b1;
            end
            default: begin alu_res = '0; alu_wb = 1'b0; end
        endcase
    end

    // Register write port: ALU results on the EXEC edge, load data on the MEM ack edge
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_idx;
        rf_wdata = alu_res;
        if (state_q == ST_EXEC && alu_wb) begin
            rf_we = 1'b1;
            if (op == OP_JAL) begin
                rf_waddr = LINK_REG;
            end
        end else if (state_q == ST_MEM && dmem_ack && op == OP_LW) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
        end
    end

    // Control FSM with registered bus requests, pc update and retire pulse.
    // imem_req is raised on the edge that leaves EXEC/MEM so a zero-wait
    // fetch completes in the first FETCH cycle (3-cycle ALU instructions).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= '0;
            instr_q      <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            retire_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    opa_q   <= rf_ra_data;
                    opb_q   <= rf_rb_data;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else if (op == OP_LW || op == OP_SW) begin
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= (op == OP_SW);
                        dmem_addr_q  <= mem_addr;
                        dmem_wdata_q <= opb_q;
                        state_q      <= ST_MEM;
                    end else begin
                        if (op == OP_JAL || op == OP_JMP) begin
                            pc_q <= tgt;
                        end else if (op == OP_BEQ && opb_q == opa_q) begin
                            pc_q <= pc_branch;
                        end else begin
                            pc_q <= pc_plus1;
                        end
                        retire_q   <= 1'b1;
                        imem_req_q <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        pc_q       <= pc_plus1;
                        retire_q   <= 1'b1;
                        imem_req_q <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath and register width (≥16).
REQ-002 SHALL have parameter PC_W, default 6, program counter and instruction-address width (≤12).
REQ-003 SHALL have parameter ADDR_W, default 8, data-memory address width (≤DATA_W).
REQ-004 SHALL have parameter NREGS, default 16, number of implemented registers (2..16).
REQ-005 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-008 SHALL have port imem_addr, output, PC_W, fetch address; always equals pc.
REQ-009 SHALL have port imem_ack, input, 1, fetch complete; imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata, input, 16, instruction word.
REQ-011 SHALL have port dmem_req, output, 1, data access request.
REQ-012 SHALL have port dmem_we, output, 1, 1 = store, 0 = load; valid while dmem_req is high.
REQ-013 SHALL have port dmem_addr, output, ADDR_W, data address.
REQ-014 SHALL have port dmem_wdata, output, DATA_W, store data.
REQ-015 SHALL have port dmem_ack, input, 1, access complete; dmem_rdata valid this cycle.
REQ-016 SHALL have port dmem_rdata, input, DATA_W, load data.
REQ-017 SHALL have port pc, output, PC_W, current program counter.
REQ-018 SHALL have port retire, output, 1, one-cycle pulse per completed instruction.
REQ-019 SHALL have port halted, output, 1, high while in HALT.
REQ-020 SHALL have ports dbg_raddr (input, 4) and dbg_rdata (output, DATA_W): combinational register read.

Function
REQ-021 SHALL decode fields as op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0]; imm4=[3:0] sign-extended; imm8=[7:0] zero-extended; tgt=[11:0] truncated to PC_W.
REQ-022 SHALL implement the FSM FETCH->DECODE->EXEC->FETCH, with EXEC->MEM->FETCH for LW/SW and EXEC->HALT for op 0000.
REQ-023 SHALL hold imem_req high in FETCH until imem_ack, latch imem_rdata on the ack edge, and ignore acks outside FETCH.
REQ-024 SHALL read rs, rt and rd operands in DECODE and register them.
REQ-025 SHALL perform writeback, pc update and the retire pulse on the EXEC edge for non-memory ops (3 cycles with zero-wait ack).
REQ-026 SHALL assert dmem_req in MEM until dmem_ack; LW writes rd and SW completes on the ack edge, then pc+1 and retire (4 cycles minimum).
REQ-027 SHALL implement ops: 0001 ADD; 0010 ADDI rs+imm4; 0011 MUL (low DATA_W bits); 0100 AND; 0101 OR; 0110 SUB rs-rt; 1001 MOV rd=rs; 1011 LI rd=imm8.
REQ-028 SHALL implement 1110 SLT and 1111 SGT: rd=1 if signed rs<rt (respectively >), else 0.
REQ-029 SHALL implement 0111 JAL (R15=zext(pc+1), pc=tgt) and 1010 JMP (pc=tgt).
REQ-030 SHALL implement 1000 BEQ: if rd==rs then pc=pc+1+sext(rt), else pc+1.
REQ-031 SHALL compute LW/SW address as (rs+imm4) modulo 2^ADDR_W; SW stores rd.
REQ-032 SHALL wrap all arithmetic modulo 2^DATA_W and all pc arithmetic modulo 2^PC_W, with no flags.
REQ-033 SHALL read R0 as 0 and discard writes to it; indices ≥NREGS SHALL read 0, writes discarded, including JAL when NREGS<16.
REQ-034 SHALL enter HALT on op 0000 without retiring; halted=1, no further requests, exit only by reset.
REQ-035 SHALL make a write in EXEC/MEM visible to the next instruction's DECODE (no hazards).

Reset
REQ-036 SHALL asynchronously set on rst: state=FETCH, pc=0, all registers=0, imem_req=dmem_req=dmem_we=0, retire=0, halted=0, dmem_addr=dmem_wdata=0.
REQ-037 SHALL abort any pending fetch or memory access on rst mid-operation, with no register write and no retire.
REQ-038 SHALL assert imem_req with imem_addr=0 on the first clock edge after rst deasserts.

Structure
REQ-039 SHALL place opcode localparams, FSM state encoding and field bit positions in shared package mc_pkg.
REQ-040 SHALL implement the register file as sub-module mc_regfile: 3 combinational reads (rs, rt/rd, dbg), 1 synchronous write, R0 zero, async reset.

Verification
REQ-041 SHALL test: LI R1,5; LI R2,7; ADD R3,R1,R2 with zero-wait memories -> dbg R3=12, retire every 3 cycles.
REQ-042 SHALL test: imem_ack delayed 4 cycles -> imem_req held high and pc stable; instruction latched only on the ack edge.
REQ-043 SHALL test: LI R4,0x20; SW R1,R4,-1; LW R5,R4,-1 -> dmem_addr=0x1F for both, R5=5; dmem_we=1 only on the store.
REQ-044 SHALL test: JAL 0x3F at pc=0x3E then HALT at 0x3F -> R15=0x3F, halted=1, no further imem_req; a subsequent pc+1 wraps to 0.
REQ-045 SHALL test: SUB R6,R0,R1 (R1=5) then SLT R7,R6,R0 -> R6=0xFFFB, R7=1; ADD R0,R1,R1 -> R0 still reads 0.
REQ-046 SHALL test: rst asserted while dmem_req is high -> dmem_req drops immediately, no write, pc=0, registers cleared.
